conv_feeder_cxy: RTL and testbench
==================================

// Module: conv_feeder_cxy
// PURPOSE
//  Transmit side of the conv core pixel interface: reads one P_WIDTH x P_HEIGHT feature map
//  from a synchronous-read buffer RAM, streams it raster-order as DIN/DIN_VALID, then drives
//  SQUEEZE to flush the 3x3 slide window. Completes when the core reports its last pixel.
//  Sits between the layer controller (START/DONE) and one conv core instance.
// PARAMETERS
//  P_WIDTH      16            feature-map width in pixels
//  P_HEIGHT     16            feature-map height in pixels
//  P_PIX_CNT_W  8             pixel counter width; must hold P_WIDTH*P_HEIGHT-1
//  P_SQZ_CNT    P_WIDTH+1     SQUEEZE cycles needed to flush the slide window
//  ADDR_W       10            buffer RAM address width
//  DW           24            pixel data width
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       asynchronous reset, active-high
//  START          in   1       one-cycle request to stream a map; honoured only when BUSY=0
//  BASE_ADDR      in   ADDR_W  RAM address of pixel (0,0); sampled with START
//  STALL          in   1       pause issuing reads/squeezes while high
//  BUSY           out  1       high from cycle after accepted START until DONE cycle inclusive
//  DONE           out  1       one-cycle pulse: map streamed and core LAST_PIX seen
//  RD_EN          out  1       RAM read enable
//  RD_ADDR        out  ADDR_W  RAM read address
//  RD_DATA        in   DW      RAM data, valid exactly 1 cycle after RD_EN
//  DIN_VALID      out  1       pixel valid to conv core
//  DIN            out  DW      pixel to conv core; 0 when DIN_VALID=0
//  SQUEEZE        out  1       flush strobe to conv core
//  CORE_LAST_PIX  in   1       LAST_PIX from conv core
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, sticky flag clear. Reset mid-map aborts
//    immediately; no DONE is produced for the aborted map.
//  - FSM: IDLE -(START)-> STREAM -(last read issued)-> FLUSH -(last squeeze issued)-> WAIT
//    -(last_seen)-> IDLE, with DONE=1 and BUSY=1 on the WAIT->IDLE cycle (both registered).
//  - STREAM: each cycle with STALL=0 issues RD_EN=1, RD_ADDR=base+pix_cnt (mod 2^ADDR_W,
//    wrap-around allowed), pix_cnt++. STALL=1 -> RD_EN=0, counters hold. Exactly
//    P_WIDTH*P_HEIGHT reads per map.
//  - Data path: RD_EN at t -> RD_DATA at t+1 -> registered DIN/DIN_VALID at t+2 (latency 2).
//  - FLUSH: each cycle with STALL=0 issues one squeeze token; exactly P_SQZ_CNT tokens.
//    Tokens use the same 2-cycle delay as reads, so SQUEEZE never overlaps DIN_VALID and
//    first SQUEEZE follows last DIN_VALID with no gap when STALL=0.
//  - STALL takes effect on issue only: up to 2 already-issued beats still appear on the
//    outputs after STALL rises (conv core has no backpressure).
//  - last_seen: sticky, set by CORE_LAST_PIX in any non-IDLE state (it may arrive during
//    FLUSH); cleared on leaving WAIT. CORE_LAST_PIX in IDLE is ignored.
//  - START while BUSY=1 ignored; START on the DONE cycle ignored (accepted next cycle).
//  - P_WIDTH*P_HEIGHT=1: STREAM lasts one issue cycle.
// STRUCTURE
//  - Package conv_cxy_pkg: FSM state encoding (IDLE/STREAM/FLUSH/WAIT), localparam
//    N_PIX = P_WIDTH*P_HEIGHT, latency constant FEED_LAT = 2.
//  - One sub-module natural: pipe_delay_cxy (N-stage register delay, async active-high
//    reset) used for the valid/squeeze token alignment. Counters/FSM inline.
// TESTING (P_WIDTH=4, P_HEIGHT=4, P_SQZ_CNT=5, RAM model with 1-cycle read)
//  1. RAM[i]=i+1, BASE=0, START, STALL=0 -> 16 consecutive DIN 1..16, then 5 SQUEEZE cycles,
//     DIN_VALID first at START+3; DONE after core model raises LAST_PIX.
//  2. STALL high 3 cycles mid-STREAM -> at most 2 beats after STALL rise, 3-cycle hole,
//     still exactly 16 pixels in order, no duplicates/drops.
//  3. BASE=0x3FA (ADDR_W=10) -> RD_ADDR 0x3FA..0x3FF then 0x000..0x009.
//  4. START pulsed while BUSY, and CORE_LAST_PIX pulsed in IDLE -> no effect; CORE_LAST_PIX
//     during FLUSH -> DONE one cycle after entering WAIT.
//  5. RST asserted at pixel 7 -> all outputs 0 same cycle (async); new START streams from
//     pixel 0, single DONE.
//  6. Back-to-back maps: START on cycle after DONE -> accepted, second map identical.

Source files
------------

// File: rtl/conv_cxy_pkg.sv
// Shared definitions for the conv core pixel feeder.
//   feed_state_t : feeder FSM states (IDLE/STREAM/FLUSH/WAIT)
//   FEED_LAT     : cycles from read/squeeze issue to the registered core-side strobe
//   n_pix()      : pixel count of a feature map
package conv_cxy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_WAIT   = 2'd3
  } feed_state_t;

  // RAM read (1 cycle) plus the output register (1 cycle)
  localparam int FEED_LAT = 2;

  function automatic int n_pix(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/pipe_delay_cxy.sv
// N-stage register delay line with asynchronous active-high reset.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous reset, active-high; clears every stage
//   d_in  in  W  value entering the delay line
//   d_out out W  d_in delayed by N cycles
module pipe_delay_cxy #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [W-1:0] stage_q [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_q[0] <= '0;
          else     stage_q[0] <= d_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_q[gi] <= '0;
          else     stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign d_out = stage_q[N-1];

endmodule

// File: rtl/conv_feeder_cxy.sv
// Transmit side of the conv core pixel interface. Reads one feature map
// raster-order from a synchronous-read buffer RAM, streams it to the core as
// din/din_valid, then issues squeeze strobes to flush the 3x3 slide window and
// waits for the core's last-pixel indication before pulsing done.
// Ports:
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   start           one-cycle request to stream a map (ignored while busy)
//   base_addr       RAM address of pixel (0,0), sampled with an accepted start
//   stall           pauses issuing reads/squeezes while high
//   busy            high from the cycle after accepted start through the done cycle
//   done            one-cycle completion pulse
//   rd_en, rd_addr  RAM read request
//   rd_data         RAM data, valid one cycle after rd_en
//   din_valid, din  pixel to the conv core (din is 0 when not valid)
//   squeeze         flush strobe to the conv core
//   core_last_pix   last-pixel indication from the conv core
module conv_feeder_cxy
  import conv_cxy_pkg::*;
#(
  parameter int P_WIDTH     = 16,
  parameter int P_HEIGHT    = 16,
  parameter int P_PIX_CNT_W = 8,
  parameter int P_SQZ_CNT   = P_WIDTH + 1,
  parameter int ADDR_W      = 10,
  parameter int DW          = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              din_valid,
  output logic [DW-1:0]     din,
  output logic              squeeze,
  input  logic              core_last_pix
);

  localparam int N_PIX = n_pix(P_WIDTH, P_HEIGHT);
  localparam int SQZ_W = (P_SQZ_CNT > 1) ? $clog2(P_SQZ_CNT) : 1;
  localparam logic [P_PIX_CNT_W-1:0] PIX_LAST = P_PIX_CNT_W'(N_PIX - 1);
  localparam logic [SQZ_W-1:0]       SQZ_LAST = SQZ_W'(P_SQZ_CNT - 1);

  feed_state_t             state_q, state_d;
  logic [P_PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [SQZ_W-1:0]        sqz_cnt_q, sqz_cnt_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    last_seen_q, last_seen_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DW-1:0]           din_q, din_d;
  logic                    din_valid_q, din_valid_d;
  logic                    squeeze_q, squeeze_d;

  logic rd_issue;
  logic sqz_issue;
  logic rd_tok;
  logic sqz_tok;

  // Issue strobes react to stall combinationally so a stalled cycle issues nothing.
  assign rd_issue  = (state_q == ST_STREAM) && !stall;
  assign sqz_issue = (state_q == ST_FLUSH)  && !stall;

  assign rd_en   = rd_issue;
  assign rd_addr = rd_issue ? (base_q + ADDR_W'(pix_cnt_q)) : '0;

  // Tokens travel one stage here to line up with rd_data; the output register
  // below supplies the second cycle of latency. Reads and squeezes are issued in
  // disjoint states, so their outputs can never overlap.
  pipe_delay_cxy #(
    .W (2),
    .N (FEED_LAT - 1)
  ) u_tok_delay (
    .clk   (clk),
    .rst   (rst),
    .d_in  ({sqz_issue, rd_issue}),
    .d_out ({sqz_tok, rd_tok})
  );

  always_comb begin
    din_d       = rd_tok ? rd_data : '0;
    din_valid_d = rd_tok;
    squeeze_d   = sqz_tok;
  end

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    sqz_cnt_d   = sqz_cnt_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // last-pixel indication is sticky once a map is in flight; it may well
    // arrive before the flush has finished issuing
    last_seen_d = last_seen_q | (core_last_pix && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        busy_d      = 1'b0;
        last_seen_d = 1'b0;
        // busy_q is still high on the done cycle, which blocks a start there
        if (start && !busy_q) begin
          state_d   = ST_STREAM;
          base_d    = base_addr;
          pix_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      ST_STREAM: begin
        busy_d = 1'b1;
        if (rd_issue) begin
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            sqz_cnt_d = '0;
            state_d   = ST_FLUSH;
          end else begin
            pix_cnt_d = pix_cnt_q + P_PIX_CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        busy_d = 1'b1;
        if (sqz_issue) begin
          if (sqz_cnt_q == SQZ_LAST) begin
            sqz_cnt_d = '0;
            state_d   = ST_WAIT;
          end else begin
            sqz_cnt_d = sqz_cnt_q + SQZ_W'(1);
          end
        end
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (last_seen_q) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          last_seen_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      sqz_cnt_q   <= '0;
      base_q      <= '0;
      last_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      squeeze_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      sqz_cnt_q   <= sqz_cnt_d;
      base_q      <= base_d;
      last_seen_q <= last_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      squeeze_q   <= squeeze_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign din       = din_q;
  assign din_valid = din_valid_q;
  assign squeeze   = squeeze_q;

endmodule

// File: tb/tb_conv_feeder_cxy.sv
// Bench for conv_feeder_cxy with a 4x4 map, 5 squeeze beats and a 1-cycle RAM.
module tb_conv_feeder_cxy;

  localparam int W = 4, H = 4, NP = 16, NSQ = 5, AW = 10, DWD = 24;

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0, core_last_pix = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW-1:0]    rd_addr;
  logic [DWD-1:0]   rd_data, din;
  logic             rd_en, din_valid, squeeze, busy, done;

  logic [DWD-1:0]   ram [1024];

  int checks = 0, failures = 0;
  int cyc = 0;

  // monitor state
  logic [DWD-1:0] pix_q[$];
  logic [AW-1:0]  rd_q[$];
  int sqz_n, viol, first_v, last_v, first_s, last_s, done_n = 0, done_cyc, exp_done = 0;
  bit vhist [8192];

  conv_feeder_cxy #(
    .P_WIDTH(W), .P_HEIGHT(H), .P_PIX_CNT_W(8), .P_SQZ_CNT(NSQ), .ADDR_W(AW), .DW(DWD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .din_valid(din_valid), .din(din), .squeeze(squeeze), .core_last_pix(core_last_pix)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en === 1'b1) rd_data <= ram[rd_addr];

  always @(negedge clk) begin
    if (rd_en === 1'b1) rd_q.push_back(rd_addr);
    if (din_valid === 1'b1) begin
      pix_q.push_back(din);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end else if (din !== '0) viol++;
    if (squeeze === 1'b1) begin
      sqz_n++;
      if (first_s < 0) first_s = cyc;
      last_s = cyc;
      if (din_valid === 1'b1) viol++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
      if (busy !== 1'b1) viol++;
    end
    vhist[cyc % 8192] = (din_valid === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // lp_mode 0: core raises last-pixel after the final squeeze; 1: at the first squeeze
  task automatic run_map(input logic [AW-1:0] base, input int lp_mode, input int stall_after,
                         input bit busy_start, input bit start_on_done, input string tag);
    int s_cyc, r_cyc, done_before, bad_p, bad_a;
    bit lp_sent, fin;
    tick();
    pix_q.delete(); rd_q.delete();
    sqz_n = 0; viol = 0; first_v = -1; last_v = -1; first_s = -1; last_s = -1;
    done_before = done_n; r_cyc = -1; lp_sent = 0; fin = 0;
    start = 1'b1; base_addr = base; s_cyc = cyc;
    for (int k = 0; k < 300 && !fin; k++) begin
      tick();
      start = busy_start && (cyc == s_cyc + 4);
      base_addr = AW'($urandom);
      core_last_pix = 1'b0;
      if (stall_after >= 0 && cyc == s_cyc + 1 + stall_after) begin
        stall = 1'b1; r_cyc = cyc;
      end else if (r_cyc >= 0 && cyc == r_cyc + 3) stall = 1'b0;
      if (!lp_sent && ((lp_mode == 0 && sqz_n == NSQ) || (lp_mode == 1 && sqz_n >= 1))) begin
        core_last_pix = 1'b1; lp_sent = 1;
      end
      if (done_n != done_before) fin = 1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, fin, 1);
    if (fin && start_on_done) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_start_on_done_ignored"}, busy, 0);
    end
    exp_done++;
    bad_p = 0; bad_a = 0;
    foreach (pix_q[i]) if (pix_q[i] !== ram[(int'(base) + i) % 1024]) bad_p++;
    foreach (rd_q[i]) if (rd_q[i] !== AW'(int'(base) + i)) bad_a++;
    $display("map %s base=0x%03h pixels=%0d squeezes=%0d first_valid=+%0d done_cyc=%0d",
             tag, base, pix_q.size(), sqz_n, first_v - s_cyc, done_cyc);
    chk({tag, "_pix_count"}, pix_q.size(), NP);
    chk({tag, "_pix_bad"}, bad_p, 0);
    chk({tag, "_rd_count"}, rd_q.size(), NP);
    chk({tag, "_rd_bad"}, bad_a, 0);
    chk({tag, "_sqz_count"}, sqz_n, NSQ);
    chk({tag, "_protocol_viol"}, viol, 0);
    chk({tag, "_first_valid_lat"}, first_v - s_cyc, 3);
    chk({tag, "_sqz_follows_pix"}, first_s, last_v + 1);
    chk({tag, "_done_count"}, done_n - done_before, 1);
    chk({tag, "_done_timing"}, done_cyc, (lp_mode == 0) ? last_s + 2 : last_s);
    if (stall_after >= 0) begin
      chk({tag, "_stall_beat0"}, vhist[r_cyc % 8192], 1);
      chk({tag, "_stall_beat1"}, vhist[(r_cyc + 1) % 8192], 1);
      chk({tag, "_stall_hole0"}, vhist[(r_cyc + 2) % 8192], 0);
      chk({tag, "_stall_hole1"}, vhist[(r_cyc + 3) % 8192], 0);
      chk({tag, "_stall_hole2"}, vhist[(r_cyc + 4) % 8192], 0);
      chk({tag, "_stall_resume"}, vhist[(r_cyc + 5) % 8192], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = (i < NP) ? DWD'(i + 1) : DWD'($urandom);

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", {busy, done, rd_en, rd_addr, din_valid, din, squeeze}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_idle_busy", busy, 0);

    // 1: plain map, RAM[i]=i+1
    run_map(10'd0, 0, -1, 0, 0, "t1");
    chk("t1_last_pixel", pix_q[NP-1], 16);

    // 2: stall mid-stream, random RAM
    for (int i = 0; i < 1024; i++) ram[i] = DWD'($urandom);
    run_map(AW'($urandom), 0, 5, 0, 0, "t2");

    // 3: address wrap
    run_map(10'h3FA, 0, -1, 0, 0, "t3");
    chk("t3_addr_first", rd_q[0], 10'h3FA);
    chk("t3_addr_wrap", rd_q[6], 10'h000);
    chk("t3_addr_last", rd_q[15], 10'h009);

    // 4a: last-pixel in IDLE ignored, start while busy ignored
    tick(); core_last_pix = 1'b1;
    tick(); core_last_pix = 1'b0;
    run_map(AW'($urandom), 0, -1, 1, 0, "t4a");
    // 4b: last-pixel during flush
    run_map(AW'($urandom), 1, -1, 0, 0, "t4b");

    // 5: reset mid-map
    tick();
    start = 1'b1; base_addr = AW'($urandom); pix_q.delete();
    tick(); start = 1'b0;
    for (int k = 0; k < 100 && pix_q.size() < 7; k++) tick();
    chk("t5_reached_pix7", pix_q.size(), 7);
    rst = 1'b1;
    #1;
    chk("t5_async_outputs", {busy, done, rd_en, rd_addr, din_valid, din, squeeze}, 0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("t5_no_done_after_abort", done_n, exp_done);
    chk("t5_idle_after_abort", busy, 0);
    run_map(AW'($urandom), 0, -1, 0, 0, "t5");

    // 6: back-to-back maps; the second also starts on its own done cycle
    run_map(AW'($urandom), 0, -1, 0, 0, "t6a");
    run_map(AW'($urandom), 0, -1, 0, 1, "t6b");
    for (int k = 0; k < 10; k++) tick();
    chk("t6_still_idle", busy, 0);
    chk("total_done", done_n, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
